// File: rtl/tri_link_pkg.sv
// Shared definitions for the triangle serial link: frame geometry and the
// transmitter state encoding, common to the sender and the deserializer.
package tri_link_pkg;

  localparam int unsigned TRI_BITS  = 144;
  localparam int unsigned TRI_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } tx_state_e;

endpackage

// File: rtl/piso_tx_if.sv
// Parallel-side valid/ready handshake between the triangle packer (master)
// and the serial transmitter (slave).
interface piso_tx_if #(
  parameter int unsigned WIDTH = tri_link_pkg::TRI_BITS
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: sends one WIDTH-bit frame LSB first with
// a bit index, a frame-start strobe before bit 0 and a done pulse on the last bit.
module piso_tx #(
  parameter int unsigned WIDTH = tri_link_pkg::TRI_BITS,
  parameter int unsigned CNT_W = tri_link_pkg::TRI_CNT_W,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_tx_if.slave         up,
  output logic             ser_out,
  output logic [CNT_W-1:0] ser_count,
  output logic             ser_start,
  output logic             tx_done
);
  import tri_link_pkg::*;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [3:0]       gap_q, gap_d;
  logic             out_d, start_d, done_d;
  logic [CNT_W-1:0] cnt_d;

  assign up.in_ready = (state_q == IDLE);

  // Outputs are registered from the next-state decode, so they change on the
  // same edge as the state they belong to; ser_count doubles as the bit counter.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    cnt_d   = '0;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (up.in_valid) begin
          state_d = LOAD;
          sr_d    = up.in_data;
          start_d = 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        out_d   = sr_q[0];
        sr_d    = sr_q >> 1;
        done_d  = (LAST_BIT == '0);
      end
      SHIFT: begin
        if (ser_count == LAST_BIT) begin
          state_d = (GAP == 0) ? IDLE : tri_link_pkg::GAP;
          gap_d   = '0;
        end else begin
          out_d  = sr_q[0];
          sr_d   = sr_q >> 1;
          cnt_d  = ser_count + CNT_W'(1);
          done_d = (ser_count + CNT_W'(1) == LAST_BIT);
        end
      end
      tri_link_pkg::GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      gap_q     <= '0;
      ser_out   <= 1'b0;
      ser_count <= '0;
      ser_start <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      gap_q     <= gap_d;
      ser_out   <= out_d;
      ser_count <= cnt_d;
      ser_start <= start_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a loopback receiver model rebuilds each frame
// from the serial outputs and is compared against the words the bench offered.
module tb_piso_tx;
  import tri_link_pkg::*;

  localparam int unsigned W  = TRI_BITS;
  localparam int unsigned CW = TRI_CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) up0 ();
  piso_tx_if #(.WIDTH(W)) up1 ();

  logic          s0_out, s0_start, s0_done;
  logic [CW-1:0] s0_count;
  logic          s1_out, s1_start, s1_done;
  logic [CW-1:0] s1_count;

  piso_tx #(.WIDTH(W), .CNT_W(CW), .GAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .up(up0),
    .ser_out(s0_out), .ser_count(s0_count), .ser_start(s0_start), .tx_done(s0_done)
  );

  piso_tx #(.WIDTH(W), .CNT_W(CW), .GAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .up(up1),
    .ser_out(s1_out), .ser_count(s1_count), .ser_start(s1_start), .tx_done(s1_done)
  );

  int checks = 0;
  int errors = 0;

  // Loopback receiver model: arms on the start strobe, stores bit ser_count on
  // the edge closing each cycle, delivers the word on tx_done.
  int           cyc = 0;
  logic [W-1:0] rx0, rx1;
  bit           act0 = 0, act1 = 0;
  logic [W-1:0] rx_q0[$], rx_q1[$];
  int           st_q0[$], st_q1[$];
  int           done0 = 0, done1 = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        act0 = 0;
        act1 = 0;
      end else begin
        if (s0_done) done0++;
        if (s0_start) begin
          act0 = 1; rx0 = '0; st_q0.push_back(cyc);
        end else if (act0) begin
          rx0[s0_count] = s0_out;
          if (s0_done) begin rx_q0.push_back(rx0); act0 = 0; end
        end
        if (s1_done) done1++;
        if (s1_start) begin
          act1 = 1; rx1 = '0; st_q1.push_back(cyc);
        end else if (act1) begin
          rx1[s1_count] = s1_out;
          if (s1_done) begin rx_q1.push_back(rx1); act1 = 0; end
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < 5; i++) w = (w << 32) | W'($urandom());
    return w;
  endfunction

  // Offer a word to dut0 and hold it until accepted; returns #1 after the accept edge.
  task automatic send0(input logic [W-1:0] w, output bit ok);
    int n = 0;
    ok = 0;
    up0.in_data  = w;
    up0.in_valid = 1'b1;
    while (!up0.in_ready && n < 400) begin @(negedge clk); n++; end
    if (up0.in_ready) begin
      @(posedge clk);
      ok = 1;
    end
    #1 up0.in_valid = 1'b0;
  endtask

  task automatic wait_frames0(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (rx_q0.size() >= n && up0.in_ready) ok = 1;
    end
  endtask

  task automatic wait_count0(input int k, output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (s0_count == CW'(k)) ok = 1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({up0.in_ready, s0_out, s0_count, s0_start, s0_done} !== {1'b1, 1'b0, {CW{1'b0}}, 2'b00}) begin
      errors++; $display("FAIL reset_dut0: got rdy=%b out=%b cnt=%0d st=%b dn=%b, want 1 0 0 0 0",
                         up0.in_ready, s0_out, s0_count, s0_start, s0_done);
    end
    checks++;
    if ({up1.in_ready, s1_out, s1_count, s1_start, s1_done} !== {1'b1, 1'b0, {CW{1'b0}}, 2'b00}) begin
      errors++; $display("FAIL reset_dut1: got rdy=%b out=%b cnt=%0d st=%b dn=%b, want 1 0 0 0 0",
                         up1.in_ready, s1_out, s1_count, s1_start, s1_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (up0.in_ready !== 1'b1 || s0_start !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got rdy=%b st=%b, want 1 0", up0.in_ready, s0_start);
    end
  endtask

  task automatic test_single_one();
    logic [W-1:0] w = W'(1);
    bit ok;
    send0(w, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got timeout, want accept"); return; end
    @(negedge clk);
    checks++;
    if (s0_start !== 1'b1 || s0_out !== 1'b0 || up0.in_ready !== 1'b0) begin
      errors++; $display("FAIL single_start: got st=%b out=%b rdy=%b, want 1 0 0", s0_start, s0_out, up0.in_ready);
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      checks++;
      if (s0_count !== CW'(k) || s0_out !== w[k] || s0_done !== (k == W - 1) || s0_start !== 1'b0) begin
        errors++; $display("FAIL single_bit%0d: got cnt=%0d out=%b dn=%b st=%b, want %0d %b %b 0",
                           k, s0_count, s0_out, s0_done, s0_start, k, w[k], (k == W - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (up0.in_ready !== 1'b0 || s0_out !== 1'b0 || s0_count !== '0 || s0_done !== 1'b0) begin
      errors++; $display("FAIL single_gap: got rdy=%b out=%b cnt=%0d dn=%b, want 0 0 0 0",
                         up0.in_ready, s0_out, s0_count, s0_done);
    end
    @(negedge clk);
    checks++;
    if (up0.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready_T147: got %b, want 1", up0.in_ready);
    end
  endtask

  task automatic test_alternating();
    logic [W-1:0] w = {(W/2){2'b10}};
    int base = rx_q0.size();
    int d0 = done0;
    bit ok;
    send0(w, ok);
    wait_frames0(base + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_timeout: got no frame, want 1"); return; end
    checks++;
    if (rx_q0[base] !== w) begin errors++; $display("FAIL alt_word: got %h want %h", rx_q0[base], w); end
    checks++;
    if (done0 - d0 !== 1) begin errors++; $display("FAIL alt_done_count: got %0d want 1", done0 - d0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] w = rand_word();
      int base = rx_q0.size();
      bit ok;
      repeat ($urandom_range(3)) @(negedge clk);
      send0(w, ok);
      wait_frames0(base + 1, ok);
      checks++;
      if (!ok || rx_q0.size() <= base) begin
        errors++; $display("FAIL rand%0d_timeout: got no frame, want 1", r);
      end else if (rx_q0[base] !== w) begin
        errors++; $display("FAIL rand%0d_word: got %h want %h", r, rx_q0[base], w);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a = rand_word(), b = rand_word(), c = rand_word(), d = rand_word();
    int b0 = rx_q0.size(), b1 = rx_q1.size();
    int sb0 = st_q0.size(), sb1 = st_q1.size();
    bit ok = 0;
    @(negedge clk);
    up0.in_data = a; up0.in_valid = 1'b1;
    up1.in_data = c; up1.in_valid = 1'b1;
    @(posedge clk);
    #1 up0.in_data = b; up1.in_data = d;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (st_q0.size() >= sb0 + 2) up0.in_valid = 1'b0;
      if (st_q1.size() >= sb1 + 2) up1.in_valid = 1'b0;
      if (!up0.in_valid && !up1.in_valid) ok = 1;
    end
    up0.in_valid = 1'b0; up1.in_valid = 1'b0;
    for (int i = 0; i < 400 && !(rx_q0.size() >= b0 + 2 && rx_q1.size() >= b1 + 2); i++) @(negedge clk);
    checks++;
    if (!ok || rx_q0.size() < b0 + 2 || rx_q1.size() < b1 + 2) begin
      errors++; $display("FAIL b2b_timeout: got %0d/%0d frames, want 2/2", rx_q0.size() - b0, rx_q1.size() - b1);
      return;
    end
    checks++;
    if (st_q0[sb0 + 1] - st_q0[sb0] !== W + 3) begin
      errors++; $display("FAIL b2b_period_gap1: got %0d want %0d", st_q0[sb0 + 1] - st_q0[sb0], W + 3);
    end
    checks++;
    if (st_q1[sb1 + 1] - st_q1[sb1] !== W + 2) begin
      errors++; $display("FAIL b2b_period_gap0: got %0d want %0d", st_q1[sb1 + 1] - st_q1[sb1], W + 2);
    end
    checks++;
    if (rx_q0[b0] !== a || rx_q0[b0 + 1] !== b) begin
      errors++; $display("FAIL b2b_words_gap1: got %h / %h want %h / %h", rx_q0[b0], rx_q0[b0 + 1], a, b);
    end
    checks++;
    if (rx_q1[b1] !== c || rx_q1[b1 + 1] !== d) begin
      errors++; $display("FAIL b2b_words_gap0: got %h / %h want %h / %h", rx_q1[b1], rx_q1[b1 + 1], c, d);
    end
  endtask

  task automatic test_data_change();
    logic [W-1:0] w = rand_word();
    int base = rx_q0.size();
    bit ok;
    send0(w, ok);
    wait_count0(50, ok);
    up0.in_data = ~w;
    wait_frames0(base + 1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL change_timeout: got no frame, want 1");
    end else if (rx_q0[base] !== w) begin
      errors++; $display("FAIL change_word: got %h want %h", rx_q0[base], w);
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] w = rand_word(), w2 = rand_word();
    int base = rx_q0.size();
    int d0 = done0;
    bit ok;
    send0(w, ok);
    wait_count0(70, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach70: got timeout, want count 70"); return; end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({up0.in_ready, s0_out, s0_count, s0_start, s0_done} !== {1'b1, 1'b0, {CW{1'b0}}, 2'b00}) begin
      errors++; $display("FAIL abort_async: got rdy=%b out=%b cnt=%0d st=%b dn=%b, want 1 0 0 0 0",
                         up0.in_ready, s0_out, s0_count, s0_start, s0_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W) @(negedge clk);
    checks++;
    if (done0 !== d0 || rx_q0.size() !== base) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses, want 0", done0 - d0);
    end
    send0(w2, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s0_count !== '0 || s0_out !== w2[0]) begin
      errors++; $display("FAIL abort_restart_bit0: got cnt=%0d out=%b, want 0 %b", s0_count, s0_out, w2[0]);
    end
    wait_frames0(base + 1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL abort_restart_timeout: got no frame, want 1");
    end else if (rx_q0[base] !== w2) begin
      errors++; $display("FAIL abort_restart_word: got %h want %h", rx_q0[base], w2);
    end
  endtask

  task automatic test_valid_during_shift();
    logic [W-1:0] w = rand_word(), w2 = rand_word();
    int base = rx_q0.size(), sb = st_q0.size();
    int n = 0;
    bit ok;
    send0(w, ok);
    wait_count0(10, ok);
    up0.in_data = w2; up0.in_valid = 1'b1;
    // Cycle T+12 (bit 10) through T+146 must show neither ready nor a new start.
    while (!up0.in_ready && n < 300) begin
      checks++;
      if (s0_start !== 1'b0) begin errors++; $display("FAIL busy_start_n%0d: got 1 want 0", n); end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W - 9) begin errors++; $display("FAIL busy_ready_low_cycles: got %0d want %0d", n, W - 9); end
    @(posedge clk);
    #1 up0.in_valid = 1'b0;
    wait_frames0(base + 2, ok);
    checks++;
    if (!ok || st_q0.size() < sb + 2) begin
      errors++; $display("FAIL busy_timeout: got %0d frames, want 2", rx_q0.size() - base);
      return;
    end
    checks++;
    if (rx_q0[base] !== w || rx_q0[base + 1] !== w2) begin
      errors++; $display("FAIL busy_words: got %h / %h want %h / %h", rx_q0[base], rx_q0[base + 1], w, w2);
    end
    checks++;
    if (st_q0[sb + 1] - st_q0[sb] !== W + 3) begin
      errors++; $display("FAIL busy_period: got %0d want %0d", st_q0[sb + 1] - st_q0[sb], W + 3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    up0.in_valid = 1'b0; up0.in_data = '0;
    up1.in_valid = 1'b0; up1.in_data = '0;
    test_reset();
    test_single_one();
    test_alternating();
    test_random();
    test_back_to_back();
    test_data_change();
    test_reset_midframe();
    test_valid_during_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter that sends one 144-bit triangle word as a serial bit stream, LSB first, one bit per clock. It produces a bit index and a frame-start strobe alongside each bit, so its outputs connect directly to the matching receive deserializer (ser_out → serial in, ser_count → count, ser_start → valid_data). It sits between the triangle packing logic and the serial link. The bit counter lives here, in the sender, because the receive side does not count bits itself.

## Interface
- WIDTH, 144: bits per frame (one triangle).
- CNT_W, 8: bit-index width; must satisfy 2^CNT_W ≥ WIDTH.
- GAP, 1: idle cycles after the last bit before in_ready reasserts. Legal range 0–15.
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  parallel frame; bit 0 is transmitted first.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  transmitter can accept; decoded as state==IDLE.
- ser_out  out  1  serial data bit; registered.
- ser_count  out  CNT_W  index of the bit currently on ser_out; registered.
- ser_start  out  1  one-cycle pulse in the cycle before bit 0; registered.
- tx_done  out  1  one-cycle pulse coincident with bit WIDTH-1; registered.

## Operation
- States:
  - IDLE: in_ready=1. An accept (in_valid && in_ready at a clock edge) loads the shift register with in_data and moves to LOAD.
  - LOAD: one cycle, ser_start=1, ser_out=0. Moves to SHIFT.
  - SHIFT: WIDTH cycles. In cycle k: ser_out = in_data[k], ser_count = k, shift register shifts right by one. In cycle k=WIDTH-1: tx_done=1, then move to GAP (or to IDLE if GAP=0).
  - GAP: GAP cycles with all outputs idle, then IDLE.
- Idle output values (every state except SHIFT): ser_out=0, ser_count=0, tx_done=0. ser_start=0 in every state except LOAD.
- in_data is sampled only on the accept edge. Changes to in_data after acceptance have no effect on the frame in flight.
- in_valid outside IDLE is ignored. Upstream must hold in_valid and in_data until accepted; nothing is dropped and nothing is queued.
- The bit counter saturates at WIDTH-1 and clears when entering LOAD. The counter never wraps inside a frame.
- Asynchronous reset, including mid-frame: state=IDLE, shift register=0, ser_out=0, ser_count=0, ser_start=0, tx_done=0. The aborted frame is not resumed and no tx_done is issued for it. in_ready reads 1 while in reset (decoded from IDLE).

## Timing
- Accept at edge T:
  - Cycle T+1: ser_start=1.
  - Cycles T+2 … T+WIDTH+1: bits 0 … WIDTH-1.
  - Cycle T+WIDTH+1: tx_done=1.
  - Cycle T+WIDTH+2+GAP: in_ready=1.
- Frame period with in_valid held high: WIDTH+2+GAP cycles (147 at defaults).
- Back-to-back frames: the next ser_start always follows the previous bit WIDTH-1 by at least one cycle. This gives the receiver's done/busy logic a strobe to re-arm on.
- Bit 0 appears exactly one cycle after ser_start. The receiver samples bit k on the edge closing cycle k.

## Structure
- Shared package tri_link_pkg holds:
  - TRI_BITS=144 and TRI_CNT_W=8, also used by the receiver.
  - The state enum {IDLE, LOAD, SHIFT, GAP}.
- Single module, no sub-modules: one FSM, one WIDTH-bit shift register, one CNT_W counter and a 4-bit gap counter.

## Test plan
- Reset release, then in_data=144'h1 with in_valid for one cycle → ser_start at T+1; ser_out=1 only at ser_count=0; tx_done at ser_count=143; in_ready=1 at T+147.
- in_data = alternating 0xA…A pattern → serial stream 0,1,0,1…; a loopback receiver's 144-bit output equals in_data and its done flag fires once.
- in_valid held high with two different words → second ser_start exactly 147 cycles after the first; both frames reconstructed correctly. Repeat with GAP=0 → period 146.
- Change in_data at ser_count=50 → transmitted bits still match the originally accepted word.
- Assert rst_n=0 at ser_count=70 → all outputs 0 immediately (asynchronously); no tx_done. After release, a new frame starts cleanly with ser_count=0.
- Assert in_valid during SHIFT → no second ser_start until after GAP; in_ready stays 0 throughout SHIFT and GAP.
